mpc_mac_acc: RTL

- Downstream stage of the pipelined signed×unsigned multiplier (21s × 12ns → 34s, ce-gated, LAT register stages) in the MPC datapath.
- Tags each operand pair issued to the multiplier, realigns the tag with the product, and accumulates a dot product.
- On the last term, emits a rounded, saturated fixed-point result through a valid/ready output.
- Owns the multiplier's ce, so output backpressure freezes the whole multiply pipeline without losing data.

---
 rtl/mpc_pkg.sv | 80 ++++++++
 rtl/mpc_tag_pipe.sv | 43 ++++
 rtl/mpc_mac_acc.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mpc_pkg.sv
// ---------------------------------------------------------------------------
// mpc_pkg
//   Shared definitions for the MPC multiply-accumulate datapath:
//     - width constants for the product, accumulator and result
//     - the {valid,last} tag that travels alongside the multiplier pipeline
//     - saturating clamp and round-shift helpers used by the accumulator
//   The helpers are sized from the constants below, so a block that uses
//   them must keep its widths equal to these constants.
// ---------------------------------------------------------------------------
package mpc_pkg;

    localparam int MPC_P_W        = 34;  // signed product width
    localparam int MPC_ACC_W      = 40;  // signed accumulator width
    localparam int MPC_OUT_W      = 21;  // signed result width
    localparam int MPC_FRAC_SHIFT = 12;  // fractional bits of the Q0.12 operand
    localparam int MPC_MUL_LAT    = 3;   // ce-enabled edges through the multiplier

    typedef struct packed {
        logic valid;
        logic last;
    } mpc_tag_t;

    // Accumulator and result limits.
    localparam logic signed [MPC_ACC_W-1:0] MPC_ACC_MAX = {1'b0, {(MPC_ACC_W-1){1'b1}}};
    localparam logic signed [MPC_ACC_W-1:0] MPC_ACC_MIN = {1'b1, {(MPC_ACC_W-1){1'b0}}};
    localparam logic signed [MPC_OUT_W-1:0] MPC_OUT_MAX = {1'b0, {(MPC_OUT_W-1){1'b1}}};
    localparam logic signed [MPC_OUT_W-1:0] MPC_OUT_MIN = {1'b1, {(MPC_OUT_W-1){1'b0}}};

    // Half an LSB of the result, expressed at accumulator scale.
    localparam logic signed [MPC_ACC_W:0] MPC_RND_HALF =
        {{(MPC_ACC_W+1-MPC_FRAC_SHIFT){1'b0}}, 1'b1, {(MPC_FRAC_SHIFT-1){1'b0}}};

    // A one-bit-wider sum fits the accumulator iff its top two bits agree.
    function automatic logic mpc_acc_ovf(input logic signed [MPC_ACC_W:0] s);
        return s[MPC_ACC_W] != s[MPC_ACC_W-1];
    endfunction

    function automatic logic signed [MPC_ACC_W-1:0] mpc_sat_acc(
        input logic signed [MPC_ACC_W:0] s
    );
        if (!mpc_acc_ovf(s)) begin
            return s[MPC_ACC_W-1:0];
        end else if (s[MPC_ACC_W]) begin
            return MPC_ACC_MIN;
        end else begin
            return MPC_ACC_MAX;
        end
    endfunction

    // Round half toward +inf, then drop the fractional bits. The add is done
    // one bit wider so it cannot wrap even at the accumulator maximum.
    function automatic logic signed [MPC_ACC_W:0] mpc_round_shift(
        input logic signed [MPC_ACC_W-1:0] a
    );
        logic signed [MPC_ACC_W:0] t;
        t = $signed({a[MPC_ACC_W-1], a}) + MPC_RND_HALF;
        return t >>> MPC_FRAC_SHIFT;
    endfunction

    // The rounded value fits the result iff every bit from the result sign
    // bit upward is a copy of the sign.
    function automatic logic mpc_out_ovf(input logic signed [MPC_ACC_W:0] r);
        logic [MPC_ACC_W-MPC_OUT_W+1:0] hi;
        hi = r[MPC_ACC_W:MPC_OUT_W-1];
        return !((&hi) || !(|hi));
    endfunction

    function automatic logic signed [MPC_OUT_W-1:0] mpc_sat_out(
        input logic signed [MPC_ACC_W:0] r
    );
        if (!mpc_out_ovf(r)) begin
            return r[MPC_OUT_W-1:0];
        end else if (r[MPC_ACC_W]) begin
            return MPC_OUT_MIN;
        end else begin
            return MPC_OUT_MAX;
        end
    endfunction

endpackage : mpc_pkg

// File: rtl/mpc_tag_pipe.sv
// ---------------------------------------------------------------------------
// mpc_tag_pipe
//   LAT-deep shift register of {valid,last} tags. It advances only on edges
//   where ce is high, exactly like the multiplier registers, so the tag at
//   the output always describes the product currently on mul_p.
//
// Ports
//   clk    in   clock
//   rst    in   asynchronous active-low reset; all stages become invalid
//   ce     in   shift enable (same enable as the multiplier)
//   tag_i  in   tag entering stage 0
//   tag_o  out  tag at stage LAT-1
// ---------------------------------------------------------------------------
module mpc_tag_pipe
    import mpc_pkg::*;
#(
    parameter int LAT = MPC_MUL_LAT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ce,
    input  mpc_tag_t tag_i,
    output mpc_tag_t tag_o
);

    mpc_tag_t stage_q [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else if (ce) begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[LAT-1];

endmodule : mpc_tag_pipe

// File: rtl/mpc_mac_acc.sv
// ---------------------------------------------------------------------------
// mpc_mac_acc
//   Sits behind the pipelined signed x unsigned multiplier of the MPC
//   datapath. Tags each operand pair issued to the multiplier, realigns the
//   tag with the product, accumulates the products of a dot product with
//   saturation, and on the last term emits a rounded, saturated result on a
//   valid/ready output. The block owns the multiplier ce, so a stalled
//   output freezes the multiplier, the tags and the accumulator together.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   operand pair presented to the multiplier this cycle
//   in_last    in   the pair is the final term (qualified by in_valid)
//   in_ready   out  term accepted this cycle (same as mul_ce)
//   mul_ce     out  multiplier clock enable
//   mul_p      in   signed product from the multiplier
//   out_data   out  rounded, saturated dot-product result
//   out_valid  out  out_data holds an unconsumed result
//   out_ready  in   downstream accepts out_data
//   out_sat    out  a clamp occurred during this dot product
// ---------------------------------------------------------------------------
module mpc_mac_acc
    import mpc_pkg::*;
#(
    // The clamp/round helpers are sized from mpc_pkg; keep these at their
    // defaults.
    parameter int P_W   = MPC_P_W,
    parameter int ACC_W = MPC_ACC_W,
    parameter int OUT_W = MPC_OUT_W,
    parameter int SHIFT = MPC_FRAC_SHIFT,
    parameter int LAT   = MPC_MUL_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    mul_ce,
    input  logic signed [P_W-1:0]   mul_p,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat
);

    logic signed [ACC_W-1:0] acc_q,      acc_d;
    logic                    acc_sat_q,  acc_sat_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_sat_q,  out_sat_d;

    mpc_tag_t tag_in;
    mpc_tag_t tag_al;
    logic     acc_en;

    logic signed [ACC_W:0]   sum_w;
    logic signed [ACC_W-1:0] sum_sat;
    logic                    acc_ovf;
    logic signed [ACC_W:0]   rnd_w;
    logic signed [OUT_W-1:0] rnd_sat;
    logic                    out_ovf;

    // The whole pipeline advances unless a result is waiting and refused.
    assign mul_ce   = !out_valid_q || out_ready;
    assign in_ready = mul_ce;

    // A bubble enters as invalid; last is meaningless without valid.
    assign tag_in = '{valid: in_valid, last: in_valid && in_last};

    mpc_tag_pipe #(
        .LAT   (LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .ce    (mul_ce),
        .tag_i (tag_in),
        .tag_o (tag_al)
    );

    assign acc_en = mul_ce && tag_al.valid;

    // One extra bit so the overflow of acc + product is visible before clamping.
    assign sum_w   = $signed({acc_q[ACC_W-1], acc_q})
                   + $signed({{(ACC_W+1-P_W){mul_p[P_W-1]}}, mul_p});
    assign acc_ovf = mpc_acc_ovf(sum_w);
    assign sum_sat = mpc_sat_acc(sum_w);

    assign rnd_w   = mpc_round_shift(sum_sat);
    assign out_ovf = mpc_out_ovf(rnd_w);
    assign rnd_sat = mpc_sat_out(rnd_w);

    always_comb begin
        acc_d       = acc_q;
        acc_sat_d   = acc_sat_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sat_d   = out_sat_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (acc_en) begin
            if (tag_al.last) begin
                // A new result on the same edge as a handshake overrides the
                // clear above, so back-to-back results leave no bubble.
                out_data_d  = rnd_sat;
                out_valid_d = 1'b1;
                out_sat_d   = acc_sat_q || acc_ovf || out_ovf;
                acc_d       = '0;
                acc_sat_d   = 1'b0;
            end else begin
                acc_d       = sum_sat;
                acc_sat_d   = acc_sat_q || acc_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            acc_sat_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_sat_q   <= acc_sat_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;

endmodule : mpc_mac_acc
